// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   - MD_* opcode encodings for the 3-bit md_op field driven by the E stage
//   - mdu_state_e : sequencer state codes (IDLE / RUN)
//   - helpers that classify an opcode as a timed mult/div operation
package mdu_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // True for the four opcodes that occupy the unit for a fixed latency.
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    // True for the two divide opcodes (they use the divide latency).
    function automatic logic is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath.
// Ports:
//   md_op    in  3   operation select (MD_* codes); non mult/div ops give zero
//   rs_val   in  32  multiplicand / dividend
//   rt_val   in  32  multiplier / divisor
//   res_hi   out 32  HI result (product high word or remainder)
//   res_lo   out 32  LO result (product low word or quotient)
//   div_zero out 1   divide op with rt_val == 0 (result must not be committed)
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_signed;
    logic        dvd_neg;
    logic        dvs_neg;
    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic [31:0] dvs_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // The low 64 bits of a product of sign-extended operands equal the
    // two's-complement signed product, so one unsigned multiplier form
    // serves both flavours.
    assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Signed divide is done on magnitudes and then re-signed: quotient
    // truncates toward zero, remainder takes the sign of the dividend.
    // 0x80000000 has magnitude 0x80000000 as an unsigned value, so
    // 0x80000000 / -1 yields 0x80000000 with remainder 0 without trapping.
    assign div_signed = (md_op == MD_DIV);
    assign dvd_neg    = div_signed & rs_val[31];
    assign dvs_neg    = div_signed & rt_val[31];
    assign dvd_mag    = dvd_neg ? (~rs_val + 32'd1) : rs_val;
    assign dvs_mag    = dvs_neg ? (~rt_val + 32'd1) : rt_val;
    // Keep the divider free of X for a zero divisor; the result is dropped.
    assign dvs_safe   = (dvs_mag == 32'd0) ? 32'd1 : dvs_mag;
    assign q_mag      = dvd_mag / dvs_safe;
    assign r_mag      = dvd_mag % dvs_safe;
    assign quot       = (dvd_neg ^ dvs_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem        = dvd_neg ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        res_hi   = 32'd0;
        res_lo   = 32'd0;
        div_zero = 1'b0;
        case (md_op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV, MD_DIVU: begin
                res_hi   = rem;
                res_lo   = quot;
                div_zero = (rt_val == 32'd0);
            end
            default: begin
                res_hi   = 32'd0;
                res_lo   = 32'd0;
                div_zero = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO registers.
// Ports:
//   clk       in  1   rising-edge clock
//   reset     in  1   asynchronous active-high; clears all state
//   start     in  1   E-stage md instruction valid this cycle
//   md_op     in  3   MD_* opcode (unlisted codes behave as NONE)
//   rs_val    in  32  forwarded GPR[rs]
//   rt_val    in  32  forwarded GPR[rt]
//   busy      out 1   mult/div in flight
//   done      out 1   one-cycle pulse after HI/LO commit of a mult/div
//   hi        out 32  HI register
//   lo        out 32  LO register
//   state_dbg out 1   current sequencer state (debug observation)
//
// Handshake: start is a valid with busy as the inverted ready. A start is
// consumed at a rising edge only when busy is low (IDLE); while busy is
// high start is ignored with no state change. The hazard unit keeps md
// instructions in D while busy, so no start is lost in practice.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output mdu_state_e  state_dbg
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_skip_q, pend_skip_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             done_q, done_d;

    logic [31:0]      calc_hi;
    logic [31:0]      calc_lo;
    logic             calc_div_zero;

    mdu_calc u_calc (
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .res_hi   (calc_hi),
        .res_lo   (calc_lo),
        .div_zero (calc_div_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pend_hi_q   <= 32'd0;
            pend_lo_q   <= 32'd0;
            pend_skip_q <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_hi_q   <= pend_hi_d;
            pend_lo_q   <= pend_lo_d;
            pend_skip_q <= pend_skip_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            done_q      <= done_d;
        end
    end

    // The result is captured at the accepting edge so later changes on the
    // forwarded operands cannot disturb it; cnt then holds the number of
    // busy cycles still to come after the current one.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_hi_d   = pend_hi_q;
        pend_lo_d   = pend_lo_q;
        pend_skip_d = pend_skip_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_muldiv(md_op)) begin
                        pend_hi_d   = calc_hi;
                        pend_lo_d   = calc_lo;
                        pend_skip_d = calc_div_zero;
                        cnt_d       = is_div(md_op) ? DIV_LOAD : MULT_LOAD;
                        state_d     = ST_RUN;
                    end else if (md_op == MD_MTHI) begin
                        hi_d = rs_val;
                    end else if (md_op == MD_MTLO) begin
                        lo_d = rs_val;
                    end
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    // Divide by zero still runs the full sequence and pulses
                    // done, but leaves HI/LO untouched.
                    if (!pend_skip_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign state_dbg = state_q;

endmodule
